// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, signed or unsigned, one quotient bit per clock.
// Define DIV_ZERO_TRAP_EN to short-circuit zero divisors through a ZERO state that raises div_zero.
//
// state | meaning
// IDLE  | waiting for start; quotient/remainder held
// CALC  | one restoring step per clock, WIDTH steps in total
// FIX   | sign correction, result write, done pulse
// ZERO  | zero-divisor early exit (DIV_ZERO_TRAP_EN builds only)

module seq_divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             div_zero
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_CALC = 2'd1;
   localparam logic [1:0] ST_FIX  = 2'd2;
`ifdef DIV_ZERO_TRAP_EN
   localparam logic [1:0] ST_ZERO = 2'd3;
   logic div_zero_q;
`endif

   logic [1:0]       state;
   logic [WIDTH-1:0] rem_q;
   logic [WIDTH-1:0] dq;
   logic [WIDTH-1:0] dvs;
   logic             neg_q;
   logic             neg_r;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] dividend_mag;
   logic [WIDTH-1:0] divisor_mag;

   // Magnitudes are unsigned, so -2^(WIDTH-1) maps cleanly onto 2^(WIDTH-1).
   always_comb begin
      dividend_mag = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
      divisor_mag  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
      trial        = {rem_q, dq[WIDTH-1]} - {1'b0, dvs};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         rem_q     <= '0;
         dq        <= '0;
         dvs       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_ZERO_TRAP_EN
         div_zero_q <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  dq    <= dividend_mag;
                  dvs   <= divisor_mag;
                  rem_q <= '0;
                  cnt   <= CNT_W'(WIDTH - 1);
                  neg_q <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                  neg_r <= is_signed && dividend[WIDTH-1];
                  busy  <= 1'b1;
`ifdef DIV_ZERO_TRAP_EN
                  div_zero_q <= 1'b0;
                  state      <= (divisor == '0) ? ST_ZERO : ST_CALC;
`else
                  state <= ST_CALC;
`endif
               end
            end
            ST_CALC: begin
               if (!trial[WIDTH]) begin
                  rem_q <= trial[WIDTH-1:0];
                  dq    <= {dq[WIDTH-2:0], 1'b1};
               end else begin
                  rem_q <= {rem_q[WIDTH-2:0], dq[WIDTH-1]};
                  dq    <= {dq[WIDTH-2:0], 1'b0};
               end
               if (cnt == '0) state <= ST_FIX;
               else           cnt   <= cnt - 1'b1;
            end
            ST_FIX: begin
               quotient  <= neg_q ? -dq : dq;
               remainder <= neg_r ? -rem_q : rem_q;
               done      <= 1'b1;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
`ifdef DIV_ZERO_TRAP_EN
            // dq holds |dividend|; re-negating recovers the raw dividend.
            ST_ZERO: begin
               quotient   <= '1;
               remainder  <= neg_r ? -dq : dq;
               div_zero_q <= 1'b1;
               done       <= 1'b1;
               busy       <= 1'b0;
               state      <= ST_IDLE;
            end
`endif
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef DIV_ZERO_TRAP_EN
   assign div_zero = div_zero_q;
`else
   assign div_zero = 1'b0;
`endif

endmodule
